// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter.
//   lock_state_e : grant lock state (UNLOCKED, LOCK0, LOCK1)
//   BMASK_*      : the byte-mask encodings accepted for stores
//   bmask_legal  : 1 when a store mask is legal at a given address offset
package dmem_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCK0    = 2'd1,
    LOCK1    = 2'd2
  } lock_state_e;

  localparam logic [3:0] BMASK_B0 = 4'b0001;
  localparam logic [3:0] BMASK_B1 = 4'b0010;
  localparam logic [3:0] BMASK_B2 = 4'b0100;
  localparam logic [3:0] BMASK_B3 = 4'b1000;
  localparam logic [3:0] BMASK_H0 = 4'b0011;
  localparam logic [3:0] BMASK_H1 = 4'b1100;
  localparam logic [3:0] BMASK_W  = 4'b1111;

  // Naturally aligned byte / halfword / word accesses only.
  function automatic logic bmask_legal(input logic [3:0] mask, input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (mask)
      BMASK_B0: ok = (off == 2'd0);
      BMASK_B1: ok = (off == 2'd1);
      BMASK_B2: ok = (off == 2'd2);
      BMASK_B3: ok = (off == 2'd3);
      BMASK_H0: ok = (off == 2'd0);
      BMASK_H1: ok = (off == 2'd2);
      BMASK_W:  ok = (off == 2'd0);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way winner select for the data-memory arbiter (purely combinational).
//   i_valid      : per-port request valid
//   i_rr_ptr     : port preferred when both are valid and no lock is held
//   i_lock_state : current lock owner; a locked port is the only candidate
//   o_grant      : one-hot winner (zero when nobody can win)
//   o_sel        : index of the winner (0 when o_grant is zero)
module dmem_rr_pick
  import dmem_pkg::*;
(
  input  logic [1:0]  i_valid,
  input  logic        i_rr_ptr,
  input  lock_state_e i_lock_state,
  output logic [1:0]  o_grant,
  output logic        o_sel
);

  always_comb begin
    o_grant = '0;
    o_sel   = 1'b0;
    case (i_lock_state)
      LOCK0: begin
        if (i_valid[0]) begin
          o_grant = 2'b01;
          o_sel   = 1'b0;
        end
      end
      LOCK1: begin
        if (i_valid[1]) begin
          o_grant = 2'b10;
          o_sel   = 1'b1;
        end
      end
      default: begin
        case (i_valid)
          2'b01: begin
            o_grant = 2'b01;
            o_sel   = 1'b0;
          end
          2'b10: begin
            o_grant = 2'b10;
            o_sel   = 1'b1;
          end
          2'b11: begin
            o_sel   = i_rr_ptr;
            o_grant = i_rr_ptr ? 2'b10 : 2'b01;
          end
          default: begin
            o_grant = '0;
            o_sel   = 1'b0;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port 16 KB data memory.
// Port 0 is the core LSU, port 1 the debug/boot loader.
//   i_clk, i_reset          : clock, synchronous active-high reset
//   i_req_*/o_req_ready     : per-port request handshake (addr/wdata/bmask/wren/lock)
//   o_rsp_valid/i_rsp_ready : per-port response handshake
//   o_rsp_rdata, o_rsp_err  : shared response payload (load data, alignment error)
//   o_mem_*, i_mem_rdata    : data memory interface (combinational read data)
//   o_lock_timeout          : one-cycle pulse when a lock is forcibly released
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 64
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [1:0]          i_req_valid,
  output logic [1:0]          o_req_ready,
  input  logic [2*ADDR_W-1:0] i_req_addr,
  input  logic [2*DATA_W-1:0] i_req_wdata,
  input  logic [7:0]          i_req_bmask,
  input  logic [1:0]          i_req_wren,
  input  logic [1:0]          i_req_lock,
  output logic [1:0]          o_rsp_valid,
  input  logic [1:0]          i_rsp_ready,
  output logic [DATA_W-1:0]   o_rsp_rdata,
  output logic                o_rsp_err,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [3:0]          o_mem_bmask,
  output logic                o_mem_wren,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                o_lock_timeout
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  lock_state_e        r_state;
  logic               r_rr;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_rdata;
  logic               r_rsp_err;
  logic               r_lock_timeout;

  logic [1:0]         w_grant;
  logic               w_sel;
  logic               w_drain;
  logic               w_slot_free;
  logic [1:0]         w_ready;
  logic [1:0]         w_accept;
  logic               w_acc;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_wdata;
  logic [3:0]         w_bmask;
  logic               w_wren;
  logic               w_lock;
  logic               w_err;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               w_cnt_max;

  dmem_rr_pick u_pick (
    .i_valid      (i_req_valid),
    .i_rr_ptr     (r_rr),
    .i_lock_state (r_state),
    .o_grant      (w_grant),
    .o_sel        (w_sel)
  );

  // Single response slot: a new transfer may enter when the slot is empty
  // or its occupant is being consumed this very cycle.
  assign w_drain     = |(r_rsp_valid & i_rsp_ready);
  assign w_slot_free = ~(|r_rsp_valid) | w_drain;
  assign w_ready     = i_reset ? 2'b00 : (w_grant & {2{w_slot_free}});
  assign w_accept    = i_req_valid & w_ready;
  assign w_acc       = |w_accept;

  always_comb begin
    w_addr  = w_sel ? i_req_addr[2*ADDR_W-1:ADDR_W]  : i_req_addr[ADDR_W-1:0];
    w_wdata = w_sel ? i_req_wdata[2*DATA_W-1:DATA_W] : i_req_wdata[DATA_W-1:0];
    w_bmask = w_sel ? i_req_bmask[7:4]               : i_req_bmask[3:0];
    w_wren  = w_sel ? i_req_wren[1]                  : i_req_wren[0];
    w_lock  = w_sel ? i_req_lock[1]                  : i_req_lock[0];
  end

  assign w_err = w_wren & ~bmask_legal(w_bmask, w_addr[1:0]);

  // The acceptance that takes the lock counts as the first locked grant.
  assign w_cnt_next = ((r_state == UNLOCKED) ? '0 : r_cnt) + CNT_W'(1);
  assign w_cnt_max  = (w_cnt_next == CNT_W'(LOCK_MAX));

  assign o_req_ready    = w_ready;
  assign o_mem_addr     = w_acc ? w_addr  : '0;
  assign o_mem_wdata    = w_acc ? w_wdata : '0;
  assign o_mem_bmask    = w_acc ? w_bmask : '0;
  assign o_mem_wren     = w_acc & w_wren & ~w_err;
  assign o_rsp_valid    = r_rsp_valid;
  assign o_rsp_rdata    = r_rsp_rdata;
  assign o_rsp_err      = r_rsp_err;
  assign o_lock_timeout = r_lock_timeout;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= UNLOCKED;
      r_rr           <= 1'b0;
      r_cnt          <= '0;
      r_rsp_valid    <= '0;
      r_rsp_rdata    <= '0;
      r_rsp_err      <= 1'b0;
      r_lock_timeout <= 1'b0;
    end else begin
      r_lock_timeout <= 1'b0;

      if (w_acc) begin
        r_rsp_valid <= w_accept;
        r_rsp_rdata <= w_wren ? '0 : i_mem_rdata;
        r_rsp_err   <= w_err;
      end else if (w_drain) begin
        r_rsp_valid <= '0;
        r_rsp_rdata <= '0;
        r_rsp_err   <= 1'b0;
      end

      if (w_acc) begin
        if (r_state == UNLOCKED) begin
          r_rr <= ~w_sel;
        end
        if (w_lock) begin
          if (w_cnt_max) begin
            r_state        <= UNLOCKED;
            r_cnt          <= '0;
            r_lock_timeout <= 1'b1;
            r_rr           <= ~w_sel;
          end else begin
            r_state <= w_sel ? LOCK1 : LOCK0;
            r_cnt   <= w_cnt_next;
          end
        end else begin
          r_state <= UNLOCKED;
          r_cnt   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 32;
  localparam int LOCK_MAX = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req_valid, req_ready, req_wren, req_lock, rsp_valid, rsp_ready;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_bmask;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_bmask;
  logic        mem_wren;
  logic [31:0] mem_rdata;
  logic        lock_timeout;

  logic [31:0] bmem   [4096];
  logic [31:0] shadow [4096];

  assign mem_rdata = bmem[mem_addr[13:2]];

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_addr     (req_addr),
    .i_req_wdata    (req_wdata),
    .i_req_bmask    (req_bmask),
    .i_req_wren     (req_wren),
    .i_req_lock     (req_lock),
    .o_rsp_valid    (rsp_valid),
    .i_rsp_ready    (rsp_ready),
    .o_rsp_rdata    (rsp_rdata),
    .o_rsp_err      (rsp_err),
    .o_mem_addr     (mem_addr),
    .o_mem_wdata    (mem_wdata),
    .o_mem_bmask    (mem_bmask),
    .o_mem_wren     (mem_wren),
    .i_mem_rdata    (mem_rdata),
    .o_lock_timeout (lock_timeout)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: owner = -1 when unlocked, rsp_port = -1 when no response held.
  int          m_rr, m_owner, m_cnt, m_rsp_port;
  logic [31:0] m_rsp_rdata;
  logic        m_rsp_err, m_tout;

  // Values sampled at the negedge, committed at the following posedge.
  int          p_win;
  logic        p_rst, p_drain, p_store, p_legal, p_lock;
  logic [15:0] p_addr;
  logic [31:0] p_wdata, p_rdata;
  logic [3:0]  p_mask;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Legal store: 1, 2 or 4 contiguous bytes starting at a size-aligned offset.
  function automatic logic legal_model(input logic [3:0] mask, input logic [1:0] off);
    int sz;
    int m;
    sz = $countones(mask);
    if (!(sz == 1 || sz == 2 || sz == 4)) return 1'b0;
    if ((int'(off) % sz) != 0) return 1'b0;
    m = ((1 << sz) - 1) << off;
    return (m == int'(mask));
  endfunction

  task automatic drive(input int p, input logic v, input logic [15:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic w, input logic l);
    req_valid[p]        = v;
    req_addr[p*16 +: 16] = a;
    req_wdata[p*32 +: 32] = d;
    req_bmask[p*4 +: 4]  = m;
    req_wren[p]         = w;
    req_lock[p]         = l;
  endtask

  task automatic sample();
    int         w;
    logic [1:0] er;
    logic [1:0] ev;
    @(negedge clk);
    w = -1;
    if (!rst && !(m_rsp_port >= 0 && !rsp_ready[m_rsp_port])) begin
      if (m_owner >= 0) begin
        if (req_valid[m_owner]) w = m_owner;
      end else if (req_valid == 2'b11) w = m_rr;
      else if (req_valid[0]) w = 0;
      else if (req_valid[1]) w = 1;
    end
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    chk("req_ready", req_ready, er);
    p_win = w;
    if (w >= 0) begin
      p_addr  = req_addr[w*16 +: 16];
      p_wdata = req_wdata[w*32 +: 32];
      p_mask  = req_bmask[w*4 +: 4];
      p_store = req_wren[w];
      p_lock  = req_lock[w];
      p_legal = legal_model(p_mask, p_addr[1:0]);
      p_rdata = shadow[p_addr[13:2]];
      chk("mem_addr", mem_addr, p_addr);
      chk("mem_bmask", mem_bmask, p_mask);
      if (p_store) chk("mem_wdata", mem_wdata, p_wdata);
      chk("mem_wren", mem_wren, p_store && p_legal);
    end else begin
      chk("mem_wren_idle", mem_wren, 1'b0);
    end
    ev = '0;
    if (m_rsp_port >= 0) ev[m_rsp_port] = 1'b1;
    chk("rsp_valid", rsp_valid, ev);
    if (m_rsp_port >= 0) begin
      chk("rsp_rdata", rsp_rdata, m_rsp_rdata);
      chk("rsp_err", rsp_err, m_rsp_err);
    end
    chk("lock_timeout", lock_timeout, m_tout);
    p_rst   = rst;
    p_drain = (m_rsp_port >= 0) && rsp_ready[m_rsp_port];
    wr_en   = mem_wren;
    wr_addr = mem_addr;
    wr_data = mem_wdata;
    wr_mask = mem_bmask;
  endtask

  task automatic advance();
    @(posedge clk);
    if (wr_en) begin
      for (int b = 0; b < 4; b++)
        if (wr_mask[b]) bmem[wr_addr[13:2]][b*8 +: 8] = wr_data[b*8 +: 8];
    end
    if (p_rst) begin
      m_rr = 0; m_owner = -1; m_cnt = 0; m_rsp_port = -1; m_tout = 1'b0;
    end else begin
      m_tout = 1'b0;
      if (p_drain) m_rsp_port = -1;
      if (p_win >= 0) begin
        m_rsp_port  = p_win;
        m_rsp_rdata = p_store ? 32'h0 : p_rdata;
        m_rsp_err   = p_store && !p_legal;
        if (p_store && p_legal) begin
          for (int b = 0; b < 4; b++)
            if (p_mask[b]) shadow[p_addr[13:2]][b*8 +: 8] = p_wdata[b*8 +: 8];
        end
        if (m_owner < 0) m_rr = 1 - p_win;
        if (p_lock) begin
          m_cnt   = ((m_owner < 0) ? 0 : m_cnt) + 1;
          m_owner = p_win;
          if (m_cnt >= LOCK_MAX) begin
            m_owner = -1; m_cnt = 0; m_tout = 1'b1; m_rr = 1 - p_win;
          end
        end else begin
          m_owner = -1; m_cnt = 0;
        end
      end
    end
    #1;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  task automatic idle_ports();
    drive(0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    drive(1, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_ports();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] old;
    logic [3:0]  lm [7];
    int          lo [7];
    int          bad;
    logic [15:0] a;
    logic [3:0]  m;
    lm = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    lo = '{0, 1, 2, 3, 0, 2, 0};

    rst = 1'b1;
    rsp_ready = 2'b00;
    req_valid = '0; req_addr = '0; req_wdata = '0; req_bmask = '0; req_wren = '0; req_lock = '0;
    for (int i = 0; i < 4096; i++) begin
      bmem[i]   = $urandom;
      shadow[i] = bmem[i];
    end
    bmem[4]   = 32'hDEADBEEF;
    shadow[4] = 32'hDEADBEEF;
    m_rr = 0; m_owner = -1; m_cnt = 0; m_rsp_port = -1; m_tout = 1'b0;
    m_rsp_rdata = '0; m_rsp_err = 1'b0;

    @(posedge clk); #1;
    cycle();
    cycle();
    rst = 1'b0;

    // Reset state
    sample();
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_mem_wren", mem_wren, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_bmask", mem_bmask, 4'h0);
    chk("rst_timeout", lock_timeout, 1'b0);
    advance();

    // Single load on port 0
    drive(0, 1'b1, 16'h0010, 32'h0, 4'hF, 1'b0, 1'b0);
    sample();
    chk("load_ready", req_ready, 2'b01);
    chk("load_mem_addr", mem_addr, 16'h0010);
    advance();
    idle_ports();
    rsp_ready = 2'b11;
    sample();
    chk("load_rsp_valid", rsp_valid, 2'b01);
    chk("load_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("load_err", rsp_err, 1'b0);
    advance();

    // Contention: strict alternation starting with port 0
    do_reset();
    rsp_ready = 2'b11;
    for (int k = 0; k < 6; k++) begin
      drive(0, 1'b1, 16'($urandom_range(0, 63) * 4), 32'h0, 4'hF, 1'b0, 1'b0);
      drive(1, 1'b1, 16'($urandom_range(0, 63) * 4), 32'h0, 4'hF, 1'b0, 1'b0);
      sample();
      chk("contend_grant", req_ready, (k % 2 == 1) ? 2'b10 : 2'b01);
      advance();
    end

    // Lock: port 1 stores with lock 1,1,0 while port 0 waits
    do_reset();
    rsp_ready = 2'b11;
    drive(0, 1'b1, 16'h0020, 32'h0, 4'hF, 1'b0, 1'b0);
    cycle();
    for (int k = 0; k < 3; k++) begin
      drive(0, 1'b1, 16'h0020, 32'h0, 4'hF, 1'b0, 1'b0);
      drive(1, 1'b1, 16'(16'h0100 + 4 * k), $urandom, 4'hF, 1'b1, (k < 2));
      sample();
      chk("lock_p0_blocked", req_ready, 2'b10);
      advance();
    end
    drive(1, 1'b1, 16'h0104, 32'h0, 4'hF, 1'b0, 1'b0);
    sample();
    chk("lock_release_p0", req_ready, 2'b01);
    advance();

    // Lock timeout after LOCK_MAX locked grants
    do_reset();
    rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      drive(0, 1'b1, 16'h0040, 32'h0, 4'hF, 1'b0, 1'b1);
      drive(1, 1'b1, 16'h0044, 32'h0, 4'hF, 1'b0, 1'b0);
      sample();
      chk("tout_hold", req_ready, 2'b01);
      chk("tout_pre", lock_timeout, 1'b0);
      advance();
    end
    sample();
    chk("tout_pulse", lock_timeout, 1'b1);
    chk("tout_p1_granted", req_ready, 2'b10);
    advance();
    sample();
    chk("tout_single", lock_timeout, 1'b0);
    advance();

    // Misaligned store, then a legal byte-2 store
    do_reset();
    rsp_ready = 2'b11;
    old = bmem[0];
    drive(0, 1'b1, 16'h0001, 32'h12345678, 4'b0011, 1'b1, 1'b0);
    sample();
    chk("mis_wren", mem_wren, 1'b0);
    advance();
    drive(0, 1'b1, 16'h0002, 32'h00AB0000, 4'b0100, 1'b1, 1'b0);
    sample();
    chk("mis_err", rsp_err, 1'b1);
    chk("mis_rdata", rsp_rdata, 32'h0);
    chk("mis_mem_unchanged", bmem[0], old);
    chk("b2_wren", mem_wren, 1'b1);
    advance();
    idle_ports();
    sample();
    chk("b2_err", rsp_err, 1'b0);
    chk("b2_mem", bmem[0], {old[31:24], 8'hAB, old[15:0]});
    advance();

    // Backpressure, then reset drops the response and the lock
    do_reset();
    rsp_ready = 2'b00;
    drive(0, 1'b1, 16'h0010, 32'h0, 4'hF, 1'b0, 1'b1);
    sample();
    chk("bp_first", req_ready, 2'b01);
    advance();
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("bp_ready", req_ready, 2'b00);
      chk("bp_rsp_valid", rsp_valid, 2'b01);
      chk("bp_rdata", rsp_rdata, 32'hDEADBEEF);
      advance();
    end
    rst = 1'b1;
    sample();
    chk("rst_no_write", mem_wren, 1'b0);
    advance();
    rst = 1'b0;
    drive(0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    drive(1, 1'b1, 16'h0030, 32'h0, 4'hF, 1'b0, 1'b0);
    sample();
    chk("rst_rsp_dropped", rsp_valid, 2'b00);
    chk("rst_lock_cleared", req_ready, 2'b10);
    advance();

    // Randomized traffic against the reference model
    do_reset();
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int p = 0; p < 2; p++) begin
        a = 16'($urandom_range(0, 15) * 4);
        if ($urandom_range(0, 1) == 1) begin
          int idx;
          idx = $urandom_range(0, 6);
          m = lm[idx];
          a[1:0] = 2'(lo[idx]);
        end else begin
          m = 4'($urandom_range(0, 15));
          a[1:0] = 2'($urandom_range(0, 3));
        end
        drive(p, ($urandom_range(0, 3) != 0), a, $urandom, m,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      rsp_ready = 2'($urandom_range(0, 3));
      cycle();
    end
    rst = 1'b0;
    idle_ports();
    cycle();

    bad = 0;
    for (int i = 0; i < 4096; i++)
      if (bmem[i] !== shadow[i]) bad++;
    chk("mem_image", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 16 KB data memory between two requesters: port 0 is the core LSU, port 1 is the debug/boot loader.
- Each port has a valid/ready request handshake and a valid/ready response handshake.
- A grant is either round-robin or locked, to support atomic sequences. A lock timeout prevents a requester from starving the other port.
- The block sits between the requesters and the data memory. It drives the memory's address, write data, byte mask and write enable, and samples its combinational read data.

Parameters:
- ADDR_W, 16, byte address width.
- DATA_W, 32, data width.
- LOCK_MAX, 64, maximum consecutive locked grants before a forced release.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_req_valid  in  2  per-port request valid; bit p belongs to port p.
- o_req_ready  out  2  per-port request ready.
- i_req_addr  in  2*ADDR_W  per-port byte address; port p occupies [p*16 +: 16].
- i_req_wdata  in  2*DATA_W  per-port write data.
- i_req_bmask  in  8  per-port byte mask, 4 bits per port.
- i_req_wren  in  2  per-port write enable; 1 = store, 0 = load.
- i_req_lock  in  2  per-port request to hold the grant after this transfer.
- o_rsp_valid  out  2  per-port response valid.
- i_rsp_ready  in  2  per-port response ready.
- o_rsp_rdata  out  DATA_W  read data; only meaningful on the port whose o_rsp_valid is high.
- o_rsp_err  out  1  alignment error flag for the current response.
- o_mem_addr  out  ADDR_W  address to the data memory.
- o_mem_wdata  out  DATA_W  write data to the data memory.
- o_mem_bmask  out  4  byte mask to the data memory.
- o_mem_wren  out  1  write enable to the data memory.
- i_mem_rdata  in  DATA_W  combinational read data from the data memory.
- o_lock_timeout  out  1  one-cycle pulse when a lock is forcibly released.

Behaviour:
- Reset: i_reset sampled high at a rising edge clears all state. After reset:
  - o_req_ready=0, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0.
  - o_mem_wren=0, o_mem_addr=0, o_mem_wdata=0, o_mem_bmask=0.
  - o_lock_timeout=0.
  - Round-robin pointer = port 0; lock state = UNLOCKED; lock counter = 0.
- Reset mid-operation: any pending response is dropped and any lock is cleared. No memory write is issued during the reset cycle.
- Grant selection (combinational, in the cycle of acceptance):
  - UNLOCKED: if only one port is valid, that port wins. If both are valid, the port selected by the rr pointer wins.
  - LOCKp: only port p may win. The other port's ready is held at 0.
- Ready rule: o_req_ready[p] = granted to p AND the response slot is empty, or is being drained this cycle by i_rsp_ready. There is exactly one response slot, so at most one transfer is outstanding.
- Acceptance: a transfer is accepted when valid&ready on a port; at most one port accepts per cycle. In that same cycle:
  - o_mem_* are driven from the winning port's address, data and mask.
  - o_mem_wren = wren AND NOT err.
  - In all other cycles o_mem_wren=0.
- Response: registered, latency 1. In the cycle after acceptance:
  - o_rsp_valid[p]=1.
  - o_rsp_rdata = i_mem_rdata captured at acceptance; 0 for stores and for errors.
  - o_rsp_valid stays held until i_rsp_ready[p].
  - Back-to-back transfers: one per cycle when the response is consumed immediately.
- Error check applies to stores only. Legal mask/addr[1:0] combinations:
  - 0001/00, 0010/01, 0100/10, 1000/11.
  - 0011/00, 1100/10.
  - 1111/00.
  - Any other store combination sets err: no memory write, o_rsp_err=1 with the response. Loads never flag err.
- rr pointer: after every UNLOCKED grant, the pointer moves to the other port.
- Lock state machine (UNLOCKED, LOCK0, LOCK1):
  - UNLOCKED -> LOCKp when port p is accepted with i_req_lock=1.
  - LOCKp -> UNLOCKED when port p is accepted with i_req_lock=0.
  - Lock counter: increments on each locked acceptance.
  - Forced release: when the counter reaches LOCK_MAX, the state goes to UNLOCKED, o_lock_timeout pulses, and rr is pointed at the other port.
  - If the locked port idles, the lock is held; idle cycles are not counted.

Decomposition:
- Package dmem_pkg holds:
  - the lock_state_e enum (UNLOCKED, LOCK0, LOCK1);
  - localparam BMASK_B0..B3, BMASK_H0, BMASK_H1, BMASK_W;
  - a function bmask_legal(mask, off).
- One natural sub-module, dmem_rr_pick: a 2-way round-robin and lock winner select, purely combinational.
- Response register and state machine live in the top module.

Test Plan:
- Single load, port 0: mem[0x0010]=0xDEADBEEF; load addr 0x0010 -> mem driven in the accept cycle; next cycle o_rsp_valid=01, rdata=0xDEADBEEF, err=0.
- Contention: both ports request every cycle, rsp_ready=11 -> grants alternate 0,1,0,1 starting with port 0 after reset; one acceptance per cycle.
- Lock: port 1 does 3 stores with lock=1,1,0 while port 0 is valid throughout -> port 0 ready=0 until port 1's third acceptance; port 0 is granted the next cycle.
- Lock timeout: LOCK_MAX=4; port 0 holds lock=1 continuously while port 1 is valid -> after the 4th acceptance, o_lock_timeout pulses once and port 1 is granted next.
- Misaligned store: bmask 0011 at addr 0x0001 -> o_mem_wren=0, memory unchanged, response err=1, rdata=0; a following bmask 0100 at addr 0x0002 with wdata 0xAB writes byte 2 only.
- Backpressure and reset: hold rsp_ready=0 -> o_req_ready=00 after the first acceptance, response held stable; asserting i_reset -> o_rsp_valid=0 and lock cleared next cycle.
